// File: rtl/conv_result_drain_pkg.sv
// Shared types for the conv result drain: FSM state encoding, the result
// beat carried through the output FIFO, and sizing helpers.
// Optional feature macro (used by conv_result_drain): CONV_DRAIN_RELU_EN.
package conv_pkg;

  localparam int BEAT_DATA_W = 16;
  localparam int BEAT_ADDR_W = 10;
  localparam int CH_W        = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CH_WAIT,
    FLUSH,
    DONE
  } drain_state_t;

  typedef struct packed {
    logic signed [BEAT_DATA_W-1:0] data;
    logic        [BEAT_ADDR_W-1:0] addr;
    logic        [CH_W-1:0]        channel;
  } result_beat_t;

  // Pixels per result channel.
  function automatic int result_n(input int w, input int h);
    return w * h;
  endfunction

  // Output FIFO depth: enough to absorb every read in flight plus two beats of slack.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/conv_result_drain_if.sv
// Read-port and result-stream signals of the conv result drain.
// master = drain side (drives read select/address and the output stream),
// slave  = wrapper/downstream side (returns read data, drives ready).
interface conv_result_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic        [2:0]            rd_select;
  logic        [ADDR_WIDTH-1:0] rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic        [ADDR_WIDTH-1:0] out_addr;
  logic        [2:0]            out_channel;

  modport master (
    output rd_select, rd_addr,
    input  rd_data,
    output out_valid, out_data, out_addr, out_channel,
    input  out_ready
  );

  modport slave (
    input  rd_select, rd_addr,
    output rd_data,
    input  out_valid, out_data, out_addr, out_channel,
    output out_ready
  );
endinterface

// File: rtl/conv_result_drain_fifo.sv
// Synchronous FIFO of result beats. Push and pop may happen in the same
// cycle, including when full (the pop frees the slot being written).
module drain_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  result_beat_t      push_beat,
  input  logic              pop,
  output result_beat_t      head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_beat_t             mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next pointer/occupancy values from the accepted push and pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers; cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Beat storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_beat;
    end
  end

endmodule

// File: rtl/conv_result_drain.sv
// Conv result drain: after a start pulse, reads every address of every
// result channel from the wrapper's fixed-latency read port and streams the
// results out on a valid/ready interface, tagged with address and channel.
// Optional feature: define CONV_DRAIN_RELU_EN to clamp negative results to 0
// as they enter the output FIFO; otherwise data passes through bit-exact.
module conv_result_drain
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH         = BEAT_DATA_W,
  parameter int FRACTION_WIDTH     = 8,
  parameter int ADDR_WIDTH         = BEAT_ADDR_W,
  parameter int CONV_RESULT_WIDTH  = 24,
  parameter int CONV_RESULT_HEIGHT = 24,
  parameter int CHANNEL_NUM        = 2,
  parameter int RD_LATENCY         = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  conv_result_drain_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int N          = result_n(CONV_RESULT_WIDTH, CONV_RESULT_HEIGHT);
  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW         = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(CHANNEL_NUM - 1);

  // Elaboration-time sanity checks on the configuration.
  if (CHANNEL_NUM < 1 || CHANNEL_NUM > 8) begin : g_bad_channel_num
    $error("conv_result_drain: CHANNEL_NUM must be 1..8");
  end
  if (FRACTION_WIDTH >= DATA_WIDTH) begin : g_bad_fraction
    $error("conv_result_drain: FRACTION_WIDTH must be below DATA_WIDTH");
  end
  if (DATA_WIDTH != BEAT_DATA_W || ADDR_WIDTH != BEAT_ADDR_W) begin : g_bad_beat_width
    $error("conv_result_drain: beat struct widths in conv_pkg must match DATA_WIDTH/ADDR_WIDTH");
  end
  if (N > (1 << ADDR_WIDTH) || RD_LATENCY < 1) begin : g_bad_geometry
    $error("conv_result_drain: result map does not fit ADDR_WIDTH or RD_LATENCY < 1");
  end

  drain_state_t               state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [RD_LATENCY-1:0]      tag_vld_q, tag_vld_d;
  logic [ADDR_WIDTH-1:0]      tag_addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]      tag_addr_d [RD_LATENCY];
  logic [CH_W-1:0]            tag_ch_q   [RD_LATENCY];
  logic [CH_W-1:0]            tag_ch_d   [RD_LATENCY];
  logic [CW-1:0]              inflight;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic                       credit_ok, issue;
  result_beat_t               push_beat, head_beat;

  function automatic logic signed [DATA_WIDTH-1:0] relu_clamp(
    input logic signed [DATA_WIDTH-1:0] v
  );
`ifdef CONV_DRAIN_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Count reads whose data has not yet been captured into the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(tag_vld_q[i]);
    end
  end

  // A read is issued only when its result is guaranteed a FIFO slot; the
  // start cycle itself issues address 0 so the first beat appears early.
  assign credit_ok = !fifo_full && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
  assign issue     = credit_ok &&
                     (((state_q == IDLE) && start) || (state_q == ISSUE));

  // Sweep FSM: next state, read channel/address and registered status outputs.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, ISSUE: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            state_d = CH_WAIT;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ISSUE;
          end
        end
      end
      CH_WAIT: begin
        // rd_select must not move until every read of this channel has returned.
        if (inflight == '0) begin
          addr_d = '0;
          if (ch_q == LAST_CH) begin
            state_d = FLUSH;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ISSUE;
          end
        end
      end
      FLUSH: begin
        if (inflight == '0 && fifo_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ch_d    = '0;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ISSUE) || (state_d == CH_WAIT) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  // Return-tag shift register: one stage per cycle of read latency.
  always_comb begin
    tag_vld_d[0]  = issue;
    tag_addr_d[0] = addr_q;
    tag_ch_d[0]   = ch_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
      tag_ch_d[i]   = tag_ch_q[i-1];
    end
  end

  // Control registers: FSM, read pointer, status outputs and tag valids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tag_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // Address/channel tags travel with their valid bit; no reset needed.
  always_ff @(posedge clk) begin
    tag_addr_q <= tag_addr_d;
    tag_ch_q   <= tag_ch_d;
  end

  // Capture returning data with the tags of the read that produced it.
  assign fifo_push         = tag_vld_q[RD_LATENCY-1];
  assign push_beat.data    = relu_clamp(bus.rd_data);
  assign push_beat.addr    = tag_addr_q[RD_LATENCY-1];
  assign push_beat.channel = tag_ch_q[RD_LATENCY-1];
  assign fifo_pop          = !fifo_empty && bus.out_ready;

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_beat (push_beat),
    .pop       (fifo_pop),
    .head      (head_beat),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head of FIFO is the output beat; fields read as zero when nothing is valid.
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = fifo_empty ? '0 : head_beat.data;
  assign bus.out_addr    = fifo_empty ? '0 : head_beat.addr;
  assign bus.out_channel = fifo_empty ? '0 : head_beat.channel;
  assign bus.rd_select   = ch_q;
  assign bus.rd_addr     = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
